vga_mem_read_arbiter: RTL and testbench
=======================================

VGA_MEM_READ_ARBITER -- requirements
Module: vga_mem_read_arbiter

Interface
REQ-001 SHALL have parameter MM_ADDR_WIDTH, default MM_MEM_ADDR_WIDTH, meaning the Avalon MM address width.
REQ-002 SHALL have parameter MM_DATA_WIDTH, default MM_MEM_DATA_WIDTH, meaning the read data width.
REQ-003 SHALL have parameter MAX_PENDING_READS, default 7, meaning the outstanding reads allowed, which sets the tag FIFO depth.
REQ-004 SHALL use one clock and an asynchronous active-low reset.
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL provide, per requester mI (I=0 frame-buffer prefetch, I=1 sprite prefetch), these Avalon MM slave ports:
- mI_read  in  1  read request.
- mI_address  in  MM_ADDR_WIDTH  word address.
- mI_byteenable  in  MM_DATA_WIDTH/8  byte enables.
- mI_waitrequest  out  1  stall.
- mI_readdata  out  MM_DATA_WIDTH  read data.
- mI_readdatavalid  out  1  data valid.
REQ-006 SHALL provide these Avalon MM master ports to memory: mm_read out 1, mm_address out MM_ADDR_WIDTH, mm_byteenable out MM_DATA_WIDTH/8, mm_waitrequest in 1, mm_readdata in MM_DATA_WIDTH, mm_readdatavalid in 1.
REQ-007 SHALL provide err_orphan  out  1, a sticky flag set when read data arrives with no read outstanding.

Function
REQ-008 SHALL accept single-word pipelined reads only, with no bursts and no writes.
REQ-009 SHALL implement FSM states IDLE and HOLD.
REQ-010 In IDLE with any mI_read=1 and tag FIFO not full, SHALL select a winner combinationally and drive the winner's read, address and byteenable onto mm_* in the same cycle (0-cycle request latency).
REQ-011 In IDLE, SHALL treat mm_waitrequest=0 as acceptance: push the winner ID into the tag FIFO and remain in IDLE.
REQ-012 In IDLE, if mm_waitrequest=1, SHALL register the winner in owner and go to HOLD.
REQ-013 In HOLD, SHALL drive only owner's signals, ignore the other requester, and return to IDLE on the accepting cycle (mm_waitrequest=0) with a tag push.
REQ-014 SHALL drive mI_waitrequest=0 only to the requester accepted in that cycle; every other mI_waitrequest SHALL be 1.
REQ-015 When the tag FIFO count equals MAX_PENDING_READS, SHALL hold mm_read=0 and both mI_waitrequest=1, judged on the count before any same-cycle pop.
REQ-016 On mm_readdatavalid=1, SHALL pop the FIFO head ID and assert mI_readdatavalid=1 for that ID only in the same cycle (0-cycle return latency).
REQ-017 SHALL drive mm_readdata combinationally to both mI_readdata.
REQ-018 Simultaneous push and pop SHALL leave the count unchanged.
REQ-019 SHALL return responses in request order and never reorder them.
REQ-020 On mm_readdatavalid=1 with the FIFO empty, SHALL drop the data, assert no mI_readdatavalid, and set err_orphan=1 until reset.
REQ-021 The count SHALL be $clog2(MAX_PENDING_READS+1) bits wide and SHALL never wrap.
REQ-022 A requester deasserting mI_read while owner in HOLD is a protocol violation; the block SHALL still complete the held transfer.

Reset
REQ-023 On reset_n=0, SHALL asynchronously clear state to IDLE, owner to 0, FIFO count and pointers to 0, last_grant to 1 and err_orphan to 0.
REQ-024 During reset, SHALL hold mm_read=0, mI_waitrequest=1 and mI_readdatavalid=0.
REQ-025 Reads outstanding at reset SHALL be forgotten; their late returns set err_orphan.

Configuration
REQ-026 With VGA_MEM_ARB_ROUND_ROBIN_EN defined, SHALL use round-robin arbitration on simultaneous requests: the requester not in last_grant wins, and last_grant updates on each acceptance.
REQ-027 With VGA_MEM_ARB_ROUND_ROBIN_EN undefined, SHALL use fixed priority with m0 always winning, and last_grant SHALL be unused.

Verification
REQ-028 SHALL cover: m0 and m1 both requesting continuously with mm_waitrequest=0, macro undefined -> only m0 is granted for 10 cycles; macro defined -> grants alternate 1-0-1-0 after reset.
REQ-029 SHALL cover: m1 request with mm_waitrequest=1 for 3 cycles while m0 requests from cycle 1 -> mm_address stays equal to m1_address for 4 cycles; m0 is granted in cycle 5.
REQ-030 SHALL cover: 7 accepted reads with no returns -> 8th request stalls (mm_read=0); one mm_readdatavalid -> next request is accepted the following cycle.
REQ-031 SHALL cover: interleaved reads m0, m1, m1, m0 with returns D0..D3 -> m0 gets D0, D3 and m1 gets D1, D2, in order.
REQ-032 SHALL cover: mm_readdatavalid pulse with no outstanding read -> err_orphan=1 and stays 1; reset_n low -> err_orphan=0 and mm_read=0 asynchronously.

Source files
------------

// File: rtl/vga_mem_read_arbiter.sv
// Two-requester Avalon MM read arbiter with an in-order tag FIFO for read-data routing.
// Define VGA_MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (m0 wins).

`ifndef MM_MEM_ADDR_WIDTH
`define MM_MEM_ADDR_WIDTH 24
`endif
`ifndef MM_MEM_DATA_WIDTH
`define MM_MEM_DATA_WIDTH 32
`endif

module vga_mem_read_arbiter #(
    parameter int MM_ADDR_WIDTH     = `MM_MEM_ADDR_WIDTH,
    parameter int MM_DATA_WIDTH     = `MM_MEM_DATA_WIDTH,
    parameter int MAX_PENDING_READS = 7
) (
    input  logic                       clk,
    input  logic                       reset_n,

    input  logic                       m0_read,
    input  logic [MM_ADDR_WIDTH-1:0]   m0_address,
    input  logic [MM_DATA_WIDTH/8-1:0] m0_byteenable,
    output logic                       m0_waitrequest,
    output logic [MM_DATA_WIDTH-1:0]   m0_readdata,
    output logic                       m0_readdatavalid,

    input  logic                       m1_read,
    input  logic [MM_ADDR_WIDTH-1:0]   m1_address,
    input  logic [MM_DATA_WIDTH/8-1:0] m1_byteenable,
    output logic                       m1_waitrequest,
    output logic [MM_DATA_WIDTH-1:0]   m1_readdata,
    output logic                       m1_readdatavalid,

    output logic                       mm_read,
    output logic [MM_ADDR_WIDTH-1:0]   mm_address,
    output logic [MM_DATA_WIDTH/8-1:0] mm_byteenable,
    input  logic                       mm_waitrequest,
    input  logic [MM_DATA_WIDTH-1:0]   mm_readdata,
    input  logic                       mm_readdatavalid,

    output logic                       err_orphan
);

    localparam int CNT_W = $clog2(MAX_PENDING_READS + 1);
    localparam int PTR_W = (MAX_PENDING_READS > 1) ? $clog2(MAX_PENDING_READS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]                   state_q, state_d;
    logic                         owner_q, owner_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [MAX_PENDING_READS-1:0] tag_q, tag_d;
    logic                         err_orphan_q, err_orphan_d;
`ifdef VGA_MEM_ARB_ROUND_ROBIN_EN
    logic [1:0]                   last_grant_q, last_grant_d;
`endif

    logic full, empty, grant_id, req_live, accept, push, pop, head_id;

    // Arbitration and request path; in HOLD the owner keeps the bus even if it drops its read.
    always_comb begin
        full  = (count_q == CNT_W'(MAX_PENDING_READS));
        empty = (count_q == '0);

        if (state_q == ST_HOLD) begin
            grant_id = owner_q;
        end else begin
`ifdef VGA_MEM_ARB_ROUND_ROBIN_EN
            if (m0_read && m1_read) begin
                grant_id = last_grant_q[0];
            end else begin
                grant_id = !m0_read;
            end
`else
            grant_id = !m0_read;
`endif
        end

        req_live      = !full && ((state_q == ST_HOLD) || m0_read || m1_read);
        mm_read       = reset_n && req_live;
        mm_address    = grant_id ? m1_address    : m0_address;
        mm_byteenable = grant_id ? m1_byteenable : m0_byteenable;

        accept = mm_read && !mm_waitrequest;
        push   = accept;
        m0_waitrequest = !(accept && !grant_id);
        m1_waitrequest = !(accept &&  grant_id);

        head_id = tag_q[rd_ptr_q];
        pop     = mm_readdatavalid && !empty;
        m0_readdatavalid = reset_n && pop && !head_id;
        m1_readdatavalid = reset_n && pop &&  head_id;
    end

    assign m0_readdata = mm_readdata;
    assign m1_readdata = mm_readdata;
    assign err_orphan  = err_orphan_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        tag_d        = tag_q;
        err_orphan_d = err_orphan_q || (mm_readdatavalid && empty);
`ifdef VGA_MEM_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant_id ? 2'b10 : 2'b01;
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (mm_read && mm_waitrequest) begin
                    state_d = ST_HOLD;
                    owner_d = grant_id;
                end
            end
            default: begin
                if (accept) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (push) begin
            tag_d[wr_ptr_q] = grant_id;
            wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_PENDING_READS - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_PENDING_READS - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tag_q        <= '0;
            err_orphan_q <= 1'b0;
`ifdef VGA_MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= 2'b01;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tag_q        <= tag_d;
            err_orphan_q <= err_orphan_d;
`ifdef VGA_MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

endmodule

// File: tb/tb_vga_mem_read_arbiter.sv
// Self-checking bench for vga_mem_read_arbiter: vector table plus a tag scoreboard for returned data.
module tb_vga_mem_read_arbiter;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          m0_read, m1_read;
    logic [AW-1:0] m0_address, m1_address;
    logic [BW-1:0] m0_byteenable, m1_byteenable;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic          mm_read;
    logic [AW-1:0] mm_address;
    logic [BW-1:0] mm_byteenable;
    logic          mm_waitrequest;
    logic [DW-1:0] mm_readdata;
    logic          mm_readdatavalid;
    logic          err_orphan;

    int errors = 0;
    int checks = 0;
    logic sb_q[$];

    always #5 clk = ~clk;

    vga_mem_read_arbiter #(
        .MM_ADDR_WIDTH(AW),
        .MM_DATA_WIDTH(DW),
        .MAX_PENDING_READS(7)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_read(m0_read), .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_read(m1_read), .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mm_read(mm_read), .mm_address(mm_address), .mm_byteenable(mm_byteenable),
        .mm_waitrequest(mm_waitrequest), .mm_readdata(mm_readdata), .mm_readdatavalid(mm_readdatavalid),
        .err_orphan(err_orphan)
    );

    typedef struct {
        logic          r0, r1;
        logic [AW-1:0] a0, a1;
        logic [BW-1:0] be0, be1;
        logic          e_read;
        logic [AW-1:0] e_addr;
        logic [BW-1:0] e_be;
        logic          e_wr0, e_wr1;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        m0_read = 1'b0; m1_read = 1'b0;
        m0_address = '0; m1_address = '0;
        m0_byteenable = '1; m1_byteenable = '1;
        mm_waitrequest = 1'b0; mm_readdatavalid = 1'b0; mm_readdata = '0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        idle_inputs();
        sb_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Called while mm_readdatavalid/mm_readdata are driven for this cycle.
    task automatic sb_return(input logic [DW-1:0] d);
        logic id;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: return with no expected read at %0t", $time);
        end else begin
            id = sb_q.pop_front();
            chk("rdv0", {63'd0, m0_readdatavalid}, {63'd0, id == 1'b0});
            chk("rdv1", {63'd0, m1_readdatavalid}, {63'd0, id == 1'b1});
            chk("rdata", id ? {32'd0, m1_readdata} : {32'd0, m0_readdata}, {32'd0, d});
        end
    endtask

    task automatic drain(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            idle_inputs();
            mm_readdatavalid = 1'b1;
            mm_readdata = base + DW'(i);
            #2;
            sb_return(base + DW'(i));
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_id;
        logic ids [4];

        //       r0    r1    a0       a1       be0    be1    read  addr     be     wr0   wr1
        vecs[0] = '{1'b1, 1'b0, 24'h111, 24'h222, 4'h3, 4'hC, 1'b1, 24'h111, 4'h3, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 24'h333, 24'h444, 4'h1, 4'h8, 1'b1, 24'h444, 4'h8, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 24'h555, 24'h666, 4'hF, 4'hF, 1'b0, 24'h000, 4'h0, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 24'h777, 24'h888, 4'h6, 4'h9, 1'b1, 24'h777, 4'h6, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 24'h999, 24'hAAA, 4'h2, 4'h4, 1'b1, 24'hAAA, 4'h4, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 24'hBBB, 24'hCCC, 4'hA, 4'h5, 1'b1, 24'hBBB, 4'hA, 1'b0, 1'b1};

        // Outputs held quiet during reset.
        reset_n = 1'b0;
        idle_inputs();
        m0_read = 1'b1; m1_read = 1'b1; mm_readdatavalid = 1'b1;
        #3;
        chk("rst_mm_read", {63'd0, mm_read}, 64'd0);
        chk("rst_wr0", {63'd0, m0_waitrequest}, 64'd1);
        chk("rst_wr1", {63'd0, m1_waitrequest}, 64'd1);
        chk("rst_rdv0", {63'd0, m0_readdatavalid}, 64'd0);
        chk("rst_rdv1", {63'd0, m1_readdatavalid}, 64'd0);
        chk("rst_err", {63'd0, err_orphan}, 64'd0);
        apply_reset();

        // Vector table: single-cycle accepts from IDLE.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            m0_read = vecs[i].r0; m1_read = vecs[i].r1;
            m0_address = vecs[i].a0; m1_address = vecs[i].a1;
            m0_byteenable = vecs[i].be0; m1_byteenable = vecs[i].be1;
            mm_waitrequest = 1'b0; mm_readdatavalid = 1'b0;
            #2;
            chk("tbl_read", {63'd0, mm_read}, {63'd0, vecs[i].e_read});
            if (vecs[i].e_read) begin
                chk("tbl_addr", {40'd0, mm_address}, {40'd0, vecs[i].e_addr});
                chk("tbl_be", {60'd0, mm_byteenable}, {60'd0, vecs[i].e_be});
            end
            chk("tbl_wr0", {63'd0, m0_waitrequest}, {63'd0, vecs[i].e_wr0});
            chk("tbl_wr1", {63'd0, m1_waitrequest}, {63'd0, vecs[i].e_wr1});
            if (!vecs[i].e_wr0) sb_q.push_back(1'b0);
            if (!vecs[i].e_wr1) sb_q.push_back(1'b1);
        end
        drain(5, 32'hA000_0000);

        // Continuous dual request with returns keeping the FIFO shallow.
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            m0_read = 1'b1; m1_read = 1'b1;
            m0_address = 24'h100; m1_address = 24'h200;
            mm_waitrequest = 1'b0;
            mm_readdatavalid = (k > 0);
            mm_readdata = 32'hB000 + DW'(k);
            #2;
`ifdef VGA_MEM_ARB_ROUND_ROBIN_EN
            exp_id = (k % 2 == 0);
`else
            exp_id = 1'b0;
`endif
            chk("dual_wr0", {63'd0, m0_waitrequest}, {63'd0, exp_id});
            chk("dual_wr1", {63'd0, m1_waitrequest}, {63'd0, !exp_id});
            chk("dual_addr", {40'd0, mm_address}, exp_id ? 64'h200 : 64'h100);
            if (k > 0) sb_return(32'hB000 + DW'(k));
            sb_q.push_back(exp_id);
        end
        drain(1, 32'hB00A);

        // Held m1 request keeps the bus through stalls; m0 wins afterwards.
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            m1_read = (k < 4); m1_address = 24'h321;
            m0_read = (k >= 1); m0_address = 24'h123;
            mm_waitrequest = (k < 3);
            #2;
            chk("hold_read", {63'd0, mm_read}, 64'd1);
            if (k < 4) begin
                chk("hold_addr", {40'd0, mm_address}, 64'h321);
                chk("hold_wr1", {63'd0, m1_waitrequest}, {63'd0, k != 3});
                chk("hold_wr0", {63'd0, m0_waitrequest}, 64'd1);
            end else begin
                chk("after_addr", {40'd0, mm_address}, 64'h123);
                chk("after_wr0", {63'd0, m0_waitrequest}, 64'd0);
                chk("after_wr1", {63'd0, m1_waitrequest}, 64'd1);
            end
            if (k == 3) sb_q.push_back(1'b1);
            if (k == 4) sb_q.push_back(1'b0);
        end
        drain(2, 32'hC000_0000);

        // Owner drops its read while held: transfer still completes.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            m0_read = (k == 0); m0_address = 24'h456;
            mm_waitrequest = (k < 2);
            #2;
            chk("drop_read", {63'd0, mm_read}, 64'd1);
            chk("drop_addr", {40'd0, mm_address}, 64'h456);
            chk("drop_wr0", {63'd0, m0_waitrequest}, {63'd0, k != 2});
            if (k == 2) sb_q.push_back(1'b0);
        end
        drain(1, 32'hC100_0000);

        // FIFO full stalls; a return frees a slot for the following cycle.
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            m0_read = 1'b1; m0_address = AW'(k);
            #2;
            chk("fill_wr0", {63'd0, m0_waitrequest}, 64'd0);
            sb_q.push_back(1'b0);
        end
        @(negedge clk);
        m0_read = 1'b1; m1_read = 1'b1;
        #2;
        chk("full_read", {63'd0, mm_read}, 64'd0);
        chk("full_wr0", {63'd0, m0_waitrequest}, 64'd1);
        chk("full_wr1", {63'd0, m1_waitrequest}, 64'd1);
        @(negedge clk);
        mm_readdatavalid = 1'b1; mm_readdata = 32'hD000_0000;
        #2;
        chk("full_pop_read", {63'd0, mm_read}, 64'd0);
        chk("full_pop_wr0", {63'd0, m0_waitrequest}, 64'd1);
        sb_return(32'hD000_0000);
        @(negedge clk);
        mm_readdatavalid = 1'b0; m1_read = 1'b0;
        #2;
        chk("refill_read", {63'd0, mm_read}, 64'd1);
        chk("refill_wr0", {63'd0, m0_waitrequest}, 64'd0);
        sb_q.push_back(1'b0);
        drain(7, 32'hD100_0000);

        // Interleaved requesters, in-order returns.
        apply_reset();
        ids[0] = 1'b0; ids[1] = 1'b1; ids[2] = 1'b1; ids[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            m0_read = !ids[k]; m1_read = ids[k];
            #2;
            chk("il_wr0", {63'd0, m0_waitrequest}, {63'd0, ids[k]});
            chk("il_wr1", {63'd0, m1_waitrequest}, {63'd0, !ids[k]});
            sb_q.push_back(ids[k]);
        end
        drain(4, 32'h0000_00D0);

        // Orphan data is dropped and flagged until reset.
        apply_reset();
        @(negedge clk);
        mm_readdatavalid = 1'b1; mm_readdata = 32'hDEAD;
        #2;
        chk("orph_rdv0", {63'd0, m0_readdatavalid}, 64'd0);
        chk("orph_rdv1", {63'd0, m1_readdatavalid}, 64'd0);
        chk("orph_err_pre", {63'd0, err_orphan}, 64'd0);
        @(negedge clk);
        mm_readdatavalid = 1'b0;
        #2;
        chk("orph_err_set", {63'd0, err_orphan}, 64'd1);
        repeat (3) @(negedge clk);
        m0_read = 1'b1;
        #2;
        chk("orph_err_sticky", {63'd0, err_orphan}, 64'd1);
        chk("orph_read", {63'd0, mm_read}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("async_err", {63'd0, err_orphan}, 64'd0);
        chk("async_read", {63'd0, mm_read}, 64'd0);

        // A read outstanding across reset returns as an orphan.
        apply_reset();
        @(negedge clk);
        m0_read = 1'b1;
        #2;
        chk("pre_rst_wr0", {63'd0, m0_waitrequest}, 64'd0);
        @(negedge clk);
        apply_reset();
        @(negedge clk);
        mm_readdatavalid = 1'b1;
        #2;
        chk("late_rdv0", {63'd0, m0_readdatavalid}, 64'd0);
        @(negedge clk);
        mm_readdatavalid = 1'b0;
        #2;
        chk("late_err", {63'd0, err_orphan}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
